nonce_reporter: RTL and testbench
=================================

NONCE_REPORTER -- requirements
Module: nonce_reporter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of golden-nonce FIFO entries; DEPTH SHALL be a power of two, at least 2.
REQ-002 The block SHALL have parameter SYNC_BYTE, default 8'h4E, meaning the frame header byte sent before each nonce.
REQ-003 Port clk: input, 1 bit, the single clock for all logic.
REQ-004 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-005 Port got_ticket: input, 1 bit, single-cycle pulse from the hashing core meaning golden_nonce is valid.
REQ-006 Port golden_nonce: input, 32 bits, the winning nonce, qualified by got_ticket.
REQ-007 Port tx_data: output, 8 bits, byte offered to the host UART transmitter.
REQ-008 Port tx_valid: output, 1 bit, tx_data is valid.
REQ-009 Port tx_ready: input, 1 bit, the UART accepts the byte this cycle.
REQ-010 Port pending: output, 1 bit, the FIFO is non-empty or a frame is in flight.
REQ-011 Port fifo_full: output, 1 bit, the FIFO occupancy equals DEPTH.
REQ-012 Port drop_count: output, 8 bits, saturating count of nonces lost to overflow.

Function
REQ-013 On each rising clk edge with got_ticket=1, golden_nonce SHALL be written to the FIFO if occupancy < DEPTH, or if a pop occurs in the same cycle.
REQ-014 A got_ticket=1 that is not accepted SHALL increment drop_count by 1, saturating at 255, and SHALL leave the FIFO unchanged.
REQ-015 The FIFO SHALL be first-in first-out; pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with log2(DEPTH)+1 bits.
REQ-016 The serializer FSM SHALL have three states: IDLE, LOAD and SEND.
REQ-017 IDLE SHALL go to LOAD when the FIFO is non-empty; otherwise it SHALL stay in IDLE.
REQ-018 LOAD SHALL pop the FIFO head into a 32-bit shift register, clear the byte index to 0, and go to SEND after exactly one cycle.
REQ-019 In SEND, tx_valid SHALL be 1; tx_data SHALL be SYNC_BYTE at index 0 and nonce bits [8i-1:8i-8] at index i=1..4, so the nonce is sent LSB byte first.
REQ-020 A byte SHALL be consumed only on a cycle where tx_valid=1 and tx_ready=1; tx_data SHALL remain stable while tx_valid=1 and tx_ready=0.
REQ-021 When index 4 is consumed, the FSM SHALL go to LOAD if the FIFO is non-empty, otherwise to IDLE; consecutive frames SHALL therefore be separated by exactly one LOAD cycle.
REQ-022 tx_valid SHALL be 0 in IDLE and in LOAD.
REQ-023 Latency: a got_ticket sampled at edge k into an empty FIFO with the FSM in IDLE SHALL give tx_valid=1 with tx_data=SYNC_BYTE after edge k+2.
REQ-024 A got_ticket arriving during SEND SHALL be queued and SHALL NOT disturb the frame in flight.
REQ-025 pending SHALL be (occupancy != 0) OR (state != IDLE).
REQ-026 fifo_full SHALL be combinational from occupancy.
REQ-027 tx_valid, tx_data and drop_count SHALL come directly from registers.

Reset
REQ-028 rst_n=0 SHALL asynchronously set: state to IDLE, occupancy and both pointers to 0, drop_count to 0, tx_valid to 0, tx_data to 8'h00, and the shift register to 0.
REQ-029 A reset in the middle of a frame SHALL abandon that frame; no partial bytes SHALL be emitted after reset.
REQ-030 FIFO storage contents SHALL NOT be reset.
REQ-031 Deassertion of rst_n SHALL be synchronised externally; the block SHALL assume no synchronous release logic of its own.

Structure
REQ-032 SYNC_BYTE, the frame length (5 bytes) and the FSM state encoding SHALL live in the shared package miner_pkg.
REQ-033 The FIFO SHALL be a separate sub-module named nonce_fifo, parameterised by DEPTH and a width of 32, with push, pop, full, empty and count ports.
REQ-034 The FSM, shift register and drop counter SHALL be in nonce_reporter.

Verification
REQ-035 Single nonce: got_ticket pulse with golden_nonce=32'hDEADBEEF, tx_ready tied to 1 -> bytes 4E, EF, BE, AD, DE on five consecutive cycles, with the first tx_valid after edge k+2; then pending=0.
REQ-036 Backpressure: same stimulus with tx_ready toggling 1/0 -> identical byte sequence; tx_data holds stable on every ready=0 cycle.
REQ-037 Overflow: DEPTH=4, tx_ready=0, six pulses with nonces 1..6 -> fifo_full=1 and drop_count=1 (the first nonce is already loaded into the shift register); after releasing tx_ready, frames for nonces 1..5 appear in order.
REQ-038 Simultaneous events: FIFO full with a pop in LOAD and got_ticket in the same cycle -> the write is accepted and drop_count is unchanged.
REQ-039 Saturation: 300 dropped pulses -> drop_count=255.
REQ-040 Mid-frame reset: assert rst_n=0 after byte 2 -> tx_valid=0 immediately (asynchronously), pending=0, drop_count=0; after release, no residual bytes are emitted.

Source files
------------

// File: rtl/miner_pkg.sv
// -----------------------------------------------------------------------------
// miner_pkg
// Shared definitions for the golden-nonce reporting path:
//   - default frame header byte
//   - frame length and last byte index
//   - serializer FSM state encoding
//   - saturating 8-bit increment helper
// No ports (package).
// -----------------------------------------------------------------------------
package miner_pkg;

  // Header byte placed in front of every nonce on the host link
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h4E;

  // One header byte plus four nonce bytes
  localparam int FRAME_BYTES = 5;
  localparam logic [2:0] LAST_BYTE_IDX = 3'(FRAME_BYTES - 1);

  // Serializer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } rep_state_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// -----------------------------------------------------------------------------
// nonce_fifo
// Small synchronous FIFO holding golden nonces waiting to be framed.
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (pointers/count only)
//   push   in   write wdata this cycle (ignored when full without a pop)
//   pop    in   drop the head entry this cycle (ignored when empty)
//   wdata  in   entry to write
//   rdata  out  current head entry (combinational read)
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  current occupancy, log2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module nonce_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] COUNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem[rd_ptr];

  // A push into a full FIFO is still legal when the head leaves in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + COUNT_ONE;
        2'b01:   count_q <= count_q - COUNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/nonce_reporter.sv
// -----------------------------------------------------------------------------
// nonce_reporter
// Queues golden nonces from the hashing core and streams each one to the host
// UART as a 5-byte frame: SYNC_BYTE, then the nonce LSB byte first.
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset (release synchronised outside)
//   got_ticket   in   one-cycle pulse, golden_nonce valid
//   golden_nonce in   winning nonce [31:0]
//   tx_data      out  byte offered to the UART (registered)
//   tx_valid     out  tx_data valid (registered)
//   tx_ready     in   UART takes the byte this cycle
//   pending      out  FIFO non-empty or a frame in flight
//   fifo_full    out  FIFO occupancy == DEPTH
//   drop_count   out  saturating count of nonces lost to overflow (registered)
// -----------------------------------------------------------------------------
module nonce_reporter
  import miner_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        got_ticket,
  input  logic [31:0] golden_nonce,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        pending,
  output logic        fifo_full,
  output logic [7:0]  drop_count
);

  localparam int AW = $clog2(DEPTH);

  rep_state_t  state;
  rep_state_t  next_state;

  logic [31:0] shift_reg;
  logic [2:0]  byte_idx;

  logic [31:0] fifo_head;
  logic        fifo_empty;
  logic [AW:0] fifo_count;
  logic        fifo_pop;
  logic        accept;
  logic        byte_done;
  logic        last_byte;

  // The head is only ever popped in LOAD, and LOAD is only entered with data queued
  assign fifo_pop  = (state == LOAD);
  assign accept    = got_ticket && (!fifo_full || (fifo_pop && !fifo_empty));
  assign byte_done = tx_valid && tx_ready;
  assign last_byte = (byte_idx == LAST_BYTE_IDX);
  assign pending   = (fifo_count != '0) || (state != IDLE);

  nonce_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (fifo_pop),
    .wdata (golden_nonce),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; back-to-back frames always pass through one LOAD cycle
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        next_state = SEND;
      end
      SEND: begin
        if (byte_done && last_byte) begin
          next_state = fifo_empty ? IDLE : LOAD;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Frame datapath. tx_data/tx_valid are registered, so LOAD already presents
  // the header byte for the first SEND cycle, and each accepted byte shifts the
  // next nonce byte out of the low end of the shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      byte_idx  <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
    end else begin
      case (state)
        LOAD: begin
          shift_reg <= fifo_head;
          byte_idx  <= '0;
          tx_valid  <= 1'b1;
          tx_data   <= SYNC_BYTE;
        end
        SEND: begin
          if (byte_done) begin
            if (last_byte) begin
              tx_valid <= 1'b0;
            end else begin
              tx_data   <= shift_reg[7:0];
              shift_reg <= shift_reg >> 8;
              byte_idx  <= byte_idx + 3'd1;
            end
          end
        end
        default: begin
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

  // Lost nonces: a ticket the FIFO could not take
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= 8'h00;
    end else if (got_ticket && !accept) begin
      drop_count <= sat_inc8(drop_count);
    end
  end

endmodule

// File: tb/tb_nonce_reporter.sv
// -----------------------------------------------------------------------------
// tb_nonce_reporter
// Directed self-checking bench for nonce_reporter (DEPTH=4, SYNC_BYTE=8'h4E).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_nonce_reporter;

  logic        clk;
  logic        rst_n;
  logic        got_ticket;
  logic [31:0] golden_nonce;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        pending;
  logic        fifo_full;
  logic [7:0]  drop_count;

  int checks;
  int failures;

  nonce_reporter #(
    .DEPTH     (4),
    .SYNC_BYTE (8'h4E)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .got_ticket   (got_ticket),
    .golden_nonce (golden_nonce),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .pending      (pending),
    .fifo_full    (fifo_full),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison point
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One-cycle got_ticket pulse; called and returns on a falling edge
  task automatic applyStimulus(input logic [31:0] nonce);
    got_ticket   = 1'b1;
    golden_nonce = nonce;
    @(negedge clk);
    got_ticket   = 1'b0;
  endtask

  // Receive one frame starting at the current falling edge. With bp set,
  // tx_ready alternates so every byte is held for one extra cycle and checked
  // twice. Returns on the falling edge after the last byte is consumed.
  task automatic recv_frame(input logic [31:0] nonce, input bit bp, input string tag);
    logic [7:0] exp_b [5];
    int idx;
    int waits;
    bit r;
    exp_b[0] = 8'h4E;
    for (int i = 1; i < 5; i++) exp_b[i] = 8'(nonce >> (8 * (i - 1)));
    idx   = 0;
    waits = 0;
    r     = 1'b1;
    while (idx < 5) begin
      if (tx_valid) begin
        checkOutput($sformatf("%s_byte%0d", tag, idx), {24'd0, tx_data}, {24'd0, exp_b[idx]});
        r = bp ? ~r : 1'b1;
        tx_ready = r;
        if (r) idx++;
      end else if (idx != 0) begin
        checkOutput($sformatf("%s_valid_gap", tag), {31'd0, tx_valid}, 32'd1);
        break;
      end else begin
        waits++;
        if (waits > 100) begin
          checkOutput($sformatf("%s_timeout", tag), {31'd0, tx_valid}, 32'd1);
          break;
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] exp1 [5];
    bit         saw_valid;
    checks       = 0;
    failures     = 0;
    got_ticket   = 1'b0;
    golden_nonce = 32'd0;
    tx_ready     = 1'b1;
    rst_n        = 1'b1;
    exp1[0] = 8'h4E; exp1[1] = 8'hEF; exp1[2] = 8'hBE; exp1[3] = 8'hAD; exp1[4] = 8'hDE;

    // Reset state
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_tx_valid",   {31'd0, tx_valid},  32'd0);
    checkOutput("rst_tx_data",    {24'd0, tx_data},   32'd0);
    checkOutput("rst_pending",    {31'd0, pending},   32'd0);
    checkOutput("rst_fifo_full",  {31'd0, fifo_full}, 32'd0);
    checkOutput("rst_drop_count", {24'd0, drop_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single nonce, tx_ready held high, latency k+2
    $display("[TB] single nonce");
    applyStimulus(32'hDEADBEEF);
    checkOutput("single_k_valid",   {31'd0, tx_valid}, 32'd0);
    checkOutput("single_k_pending", {31'd0, pending},  32'd1);
    @(negedge clk);
    checkOutput("single_k1_valid",  {31'd0, tx_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("single_valid%0d", i), {31'd0, tx_valid}, 32'd1);
      checkOutput($sformatf("single_byte%0d", i),  {24'd0, tx_data},  {24'd0, exp1[i]});
    end
    @(negedge clk);
    checkOutput("single_end_valid",   {31'd0, tx_valid}, 32'd0);
    checkOutput("single_end_pending", {31'd0, pending},  32'd0);

    // Same nonce under backpressure
    $display("[TB] backpressure");
    applyStimulus(32'hDEADBEEF);
    recv_frame(32'hDEADBEEF, 1'b1, "bp");
    checkOutput("bp_end_pending", {31'd0, pending}, 32'd0);
    tx_ready = 1'b1;

    // Overflow: six back-to-back tickets with the UART stalled
    $display("[TB] overflow");
    tx_ready = 1'b0;
    for (int n = 1; n <= 6; n++) applyStimulus(32'(n));
    checkOutput("ovf_fifo_full",  {31'd0, fifo_full},  32'd1);
    checkOutput("ovf_drop_count", {24'd0, drop_count}, 32'd1);
    checkOutput("ovf_hold_valid", {31'd0, tx_valid},   32'd1);
    checkOutput("ovf_hold_data",  {24'd0, tx_data},    32'h4E);
    recv_frame(32'd1, 1'b0, "ovf_n1");
    // Now in LOAD with a full FIFO: a ticket here rides on the pop
    checkOutput("sim_load_valid", {31'd0, tx_valid},  32'd0);
    checkOutput("sim_load_full",  {31'd0, fifo_full}, 32'd1);
    applyStimulus(32'h0000_0007);
    checkOutput("sim_full_after", {31'd0, fifo_full},  32'd1);
    checkOutput("sim_drop_same",  {24'd0, drop_count}, 32'd1);
    recv_frame(32'd2, 1'b0, "ovf_n2");
    recv_frame(32'd3, 1'b0, "ovf_n3");
    recv_frame(32'd4, 1'b0, "ovf_n4");
    recv_frame(32'd5, 1'b0, "ovf_n5");
    recv_frame(32'd7, 1'b0, "sim_n7");
    checkOutput("ovf_end_pending", {31'd0, pending}, 32'd0);

    // Saturation: 5 tickets are absorbed, the rest are dropped on top of 1
    $display("[TB] saturation");
    tx_ready = 1'b0;
    for (int n = 0; n < 258; n++) applyStimulus(32'h1000_0000 + 32'(n));
    checkOutput("sat_drop_254", {24'd0, drop_count}, 32'd254);
    checkOutput("sat_full",     {31'd0, fifo_full},  32'd1);
    applyStimulus(32'h2000_0000);
    checkOutput("sat_drop_255", {24'd0, drop_count}, 32'd255);
    for (int n = 0; n < 50; n++) applyStimulus(32'h3000_0000 + 32'(n));
    checkOutput("sat_drop_hold", {24'd0, drop_count}, 32'd255);
    checkOutput("sat_pending",   {31'd0, pending},    32'd1);

    // Mid-frame reset after two bytes have gone out
    $display("[TB] mid-frame reset");
    tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tx_ready = 1'b0;
    checkOutput("mfr_pre_valid", {31'd0, tx_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mfr_valid",   {31'd0, tx_valid},   32'd0);
    checkOutput("mfr_pending", {31'd0, pending},    32'd0);
    checkOutput("mfr_drop",    {24'd0, drop_count}, 32'd0);
    checkOutput("mfr_data",    {24'd0, tx_data},    32'd0);
    checkOutput("mfr_full",    {31'd0, fifo_full},  32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    saw_valid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (tx_valid || pending) saw_valid = 1'b1;
    end
    checkOutput("mfr_no_residual", {31'd0, saw_valid}, 32'd0);
    applyStimulus(32'h1234_5678);
    recv_frame(32'h1234_5678, 1'b0, "post_rst");
    checkOutput("post_rst_pending", {31'd0, pending}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
